nasti_narrow_read_slave: RTL

Read-only NASTI slave that sits directly downstream of the lite-to-NASTI read converter. It accepts AR bursts on the narrow NASTI side, queues up to `AR_DEPTH` of them, and walks each burst against a synchronous single-port memory (1-cycle read latency). It returns one R beat per address, with `r_last`, `r_id` and `r_user` taken from the burst.

---
 rtl/nasti_narrow_read_slave.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/nasti_narrow_read_slave.sv
// Read-only NASTI slave: queues AR bursts, walks each one against a 1-cycle synchronous memory.
// Latency: AR accept at edge N -> mem_en in cycle after N+1 -> r_valid after N+2; one beat per 2 cycles.
// Backpressure: r_ready low holds all R outputs; ar_ready drops while the AR queue is full.
module nasti_narrow_read_slave #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int AR_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   nasti_ar_id,
    input  logic [ADDR_WIDTH-1:0] nasti_ar_addr,
    input  logic [7:0]            nasti_ar_len,
    input  logic [2:0]            nasti_ar_size,
    input  logic [1:0]            nasti_ar_burst,
    input  logic [USER_WIDTH-1:0] nasti_ar_user,
    input  logic                  nasti_ar_valid,
    output logic                  nasti_ar_ready,
    output logic [ID_WIDTH-1:0]   nasti_r_id,
    output logic [DATA_WIDTH-1:0] nasti_r_data,
    output logic [1:0]            nasti_r_resp,
    output logic                  nasti_r_last,
    output logic [USER_WIDTH-1:0] nasti_r_user,
    output logic                  nasti_r_valid,
    input  logic                  nasti_r_ready,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SZ_MAX = $clog2(DATA_WIDTH / 8);
    localparam int EW     = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + USER_WIDTH;
    localparam int PW     = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
    localparam int CW     = $clog2(AR_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t state, state_nxt;

    // ---------------- AR queue ----------------
    logic [EW-1:0] q_mem [AR_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] q_cnt;
    logic          q_full, q_empty, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(AR_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign q_full         = (q_cnt == CW'(AR_DEPTH));
    assign q_empty        = (q_cnt == '0);
    assign nasti_ar_ready = !q_full;
    assign push           = nasti_ar_valid && !q_full;
    assign pop            = (state == IDLE) && !q_empty;

    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= {nasti_ar_id, nasti_ar_addr, nasti_ar_len,
                              nasti_ar_size, nasti_ar_burst, nasti_ar_user};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      q_cnt <= q_cnt + CW'(1);
            else if (!push && pop) q_cnt <= q_cnt - CW'(1);
        end
    end

    // ---------------- queue head decode ----------------
    logic [ID_WIDTH-1:0]   h_id;
    logic [ADDR_WIDTH-1:0] h_addr, h_mask;
    logic [7:0]            h_len;
    logic [2:0]            h_size;
    logic [1:0]            h_burst;
    logic [USER_WIDTH-1:0] h_user;
    logic                  h_err;

    assign {h_id, h_addr, h_len, h_size, h_burst, h_user} = q_mem[rd_ptr];

    always_comb begin
        h_err  = 1'b0;
        h_mask = ADDR_WIDTH'(((32'(h_len) + 32'd1) << h_size) - 32'd1);
        if (h_size > 3'(SZ_MAX))
            h_err = 1'b1;
        if (h_burst == 2'd3)
            h_err = 1'b1;
        if (h_burst == 2'd2 && !(h_len == 8'd1 || h_len == 8'd3 || h_len == 8'd7 || h_len == 8'd15))
            h_err = 1'b1;
    end

    // ---------------- burst state ----------------
    logic [ID_WIDTH-1:0]   b_id;
    logic [ADDR_WIDTH-1:0] b_addr, b_mask, b_step, b_inc, b_next;
    logic [7:0]            b_rem;
    logic [2:0]            b_size;
    logic [1:0]            b_burst;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_err;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  fresh;
    logic                  r_hs, r_last_int;

    assign b_step = ADDR_WIDTH'(1) << b_size;
    assign b_inc  = b_addr + b_step;

    always_comb begin
        b_next = b_addr;
        case (b_burst)
            2'd1:    b_next = b_inc;
            2'd2:    b_next = (b_addr & ~b_mask) | (b_inc & b_mask);
            default: b_next = b_addr;
        endcase
    end

    assign r_last_int = (b_rem == 8'd0);
    assign r_hs       = (state == RESP) && nasti_r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!q_empty) state_nxt = FETCH;
            FETCH:   state_nxt = RESP;
            RESP:    if (r_hs) state_nxt = r_last_int ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_id    <= '0;
            b_addr  <= '0;
            b_mask  <= '0;
            b_rem   <= '0;
            b_size  <= '0;
            b_burst <= '0;
            b_user  <= '0;
            b_err   <= 1'b0;
            data_q  <= '0;
            fresh   <= 1'b0;
        end else begin
            fresh <= (state == FETCH);
            if (fresh)
                data_q <= nasti_r_data;
            if (pop) begin
                b_id    <= h_id;
                b_addr  <= h_addr;
                b_mask  <= h_mask;
                b_rem   <= h_len;
                b_size  <= h_size;
                b_burst <= h_burst;
                b_user  <= h_user;
                b_err   <= h_err;
            end else if (r_hs && !r_last_int) begin
                b_rem  <= b_rem - 8'd1;
                b_addr <= b_next;
            end
        end
    end

    // Memory data is live only in the first RESP cycle; data_q holds it through back-pressure.
    assign nasti_r_data  = fresh ? (b_err ? '0 : mem_rdata) : data_q;
    assign nasti_r_valid = (state == RESP);
    assign nasti_r_last  = (state == RESP) && r_last_int;
    assign nasti_r_resp  = b_err ? 2'b10 : 2'b00;
    assign nasti_r_id    = b_id;
    assign nasti_r_user  = b_user;
    assign mem_en        = (state == FETCH) && !b_err;
    assign mem_addr      = b_addr;

endmodule
